pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised, registered program-counter unit for the LEGv8 datapath. It replaces the purely combinational next-PC selector with an owned PC register and a small run/halt/trap state machine. It also adds a register-indirect branch (BR), a CBNZ polarity input, pipeline stall, and misaligned-target trapping. It sits at the head of fetch and drives the instruction-memory address directly.

## Interface
- ADDR_W, 64, PC and target width in bits
- INSTR_SHIFT, 2, log2 of instruction size; branch offsets are shifted left by this amount, and the sequential increment is 1<<INSTR_SHIFT
- RESET_PC, 0, PC value loaded on reset
- TRAP_VEC, 'h80, PC loaded on a trap (used only when PC_TRAP_EN is defined)
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Stall  input  1  hold the PC and state for this cycle
- Branch  input  1  conditional branch (CBZ/CBNZ)
- BranchNZ  input  1  invert the condition (CBNZ)
- ALUZero  input  1  zero flag for the instruction at CurrentPC
- Uncondbranch  input  1  PC-relative unconditional branch (B/BL)
- RegBranch  input  1  register-indirect branch (BR)
- RegTarget  input  ADDR_W  BR target address
- SignExtImm  input  ADDR_W  sign-extended word offset
- Halt  input  1  HLT decoded at CurrentPC
- Resume  input  1  leave the HALT state
- TrapAck  input  1  acknowledge a pending trap
- CurrentPC  output  ADDR_W  registered PC
- NextPC  output  ADDR_W  combinational value that loads at the next edge
- LinkPC  output  ADDR_W  CurrentPC + (1<<INSTR_SHIFT); combinational, for BL
- Taken  output  1  combinational; the branch is redirecting this cycle
- Halted  output  1  registered; state == HALT
- Trap  output  1  registered; state == TRAP
- EPC  output  ADDR_W  registered PC of the faulting BR

## Operation
- States: RUN, HALT, TRAP. Reset enters RUN.
- Seq = CurrentPC + (1<<INSTR_SHIFT).
- Rel = CurrentPC + (SignExtImm << INSTR_SHIFT).
- All sums are modulo 2^ADDR_W, so wrap-around is silent.
- CondTaken = Branch & (ALUZero ^ BranchNZ).
- NextPC selection in RUN, highest priority first:
  - Stall: CurrentPC.
  - Halt: CurrentPC, then go to HALT.
  - RegBranch: RegTarget.
  - Uncondbranch: Rel.
  - CondTaken: Rel.
  - Otherwise: Seq.
- Taken = 1 when the RegBranch, Uncondbranch or CondTaken arm is selected and Stall = 0.
- HALT:
  - PC holds.
  - Resume (with Stall = 0) loads Seq and returns to RUN.
  - Branch inputs are ignored.
- TRAP:
  - PC holds at TRAP_VEC.
  - TrapAck returns to RUN without changing the PC; the instruction at TRAP_VEC is fetched next.
  - Stall has no effect in TRAP.
- A misaligned BR is a RegBranch in RUN, not stalled, with RegTarget[INSTR_SHIFT-1:0] != 0. Handling is set by PC_TRAP_EN (see Configuration).
- Simultaneous Halt and branch: Halt wins and the branch is dropped.
- Simultaneous RegBranch and Uncondbranch: RegBranch wins.

## Timing
- One-cycle latency: NextPC appears on CurrentPC after the next rising edge.
- Reset values: CurrentPC = RESET_PC, state = RUN, Halted = 0, Trap = 0, EPC = 0.
- Reset is honoured in any state, including mid-HALT and mid-TRAP, and always reaches RUN at RESET_PC on the next edge.
- Trap asserts in the cycle after the faulting BR. It stays high for at least one cycle and until a TrapAck is sampled.
- TrapAck sampled in RUN is ignored.
- Resume sampled in RUN is ignored.

## Configuration
- PC_TRAP_EN defined:
  - A misaligned BR loads TRAP_VEC, captures the faulting CurrentPC in EPC and enters TRAP.
- PC_TRAP_EN undefined:
  - The TRAP state and its logic are absent; Trap is tied to 0 and EPC to 0.
  - A misaligned BR loads RegTarget with its low INSTR_SHIFT bits cleared.
  - TrapAck is unused.

## Test plan
- Reset, then 3 idle cycles -> CurrentPC goes 0x0, 0x4, 0x8, 0xC; Halted = 0, Trap = 0.
- CurrentPC = 0x100, Branch = 1, ALUZero = 1, SignExtImm = -4 -> next PC 0xF0, Taken = 1. Repeat with BranchNZ = 1 -> next PC 0x104, Taken = 0.
- Uncondbranch at 0x200 with SignExtImm = 0x10 and Stall = 1 for 2 cycles -> PC holds 0x200. Release Stall -> PC 0x240. LinkPC reads 0x204 throughout.
- BR with RegTarget = 0x2002 at PC 0x300:
  - PC_TRAP_EN defined -> PC = 0x80, Trap = 1, EPC = 0x300. Trap holds 3 cycles without TrapAck. TrapAck -> RUN, PC goes 0x80, then 0x84.
  - PC_TRAP_EN undefined -> PC = 0x2000.
- Halt at PC 0x40 -> Halted = 1 and PC stays 0x40 for 5 cycles. Resume -> PC 0x44. Then Reset asserted during a later HALT -> PC 0x0, Halted = 0.
- CurrentPC = 0xFFFF_FFFF_FFFF_FFFC, no branch -> PC wraps to 0x0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the control inputs and PC outputs of pc_sequencer.
// Signal suffixes are written from the sequencer's point of view:
// _i is driven into the sequencer, and _o is driven by it.
//
//   Controls : stall_i, branch_i, branch_nz_i, alu_zero_i, uncondbranch_i,
//              reg_branch_i, reg_target_i, sign_ext_imm_i, halt_i, resume_i,
//              trap_ack_i
//   Results  : current_pc_o, next_pc_o, link_pc_o, taken_o, halted_o,
//              trap_o, epc_o
//
// Modports
//   slave  : used by the sequencer
//   master : used by the decode/control side
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_W = 64
);
  logic              stall_i;
  logic              branch_i;
  logic              branch_nz_i;
  logic              alu_zero_i;
  logic              uncondbranch_i;
  logic              reg_branch_i;
  logic [ADDR_W-1:0] reg_target_i;
  logic [ADDR_W-1:0] sign_ext_imm_i;
  logic              halt_i;
  logic              resume_i;
  logic              trap_ack_i;

  logic [ADDR_W-1:0] current_pc_o;
  logic [ADDR_W-1:0] next_pc_o;
  logic [ADDR_W-1:0] link_pc_o;
  logic              taken_o;
  logic              halted_o;
  logic              trap_o;
  logic [ADDR_W-1:0] epc_o;

  modport slave (
    input  stall_i, branch_i, branch_nz_i, alu_zero_i, uncondbranch_i,
           reg_branch_i, reg_target_i, sign_ext_imm_i, halt_i, resume_i,
           trap_ack_i,
    output current_pc_o, next_pc_o, link_pc_o, taken_o, halted_o, trap_o,
           epc_o
  );

  modport master (
    output stall_i, branch_i, branch_nz_i, alu_zero_i, uncondbranch_i,
           reg_branch_i, reg_target_i, sign_ext_imm_i, halt_i, resume_i,
           trap_ack_i,
    input  current_pc_o, next_pc_o, link_pc_o, taken_o, halted_o, trap_o,
           epc_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// This is the registered program counter for the LEGv8 fetch stage.
// A RUN/HALT/TRAP state machine controls it.
//
// Next-PC selection in RUN, from highest to lowest priority:
//   stall, halt, register branch (BR), B/BL, taken CBZ/CBNZ, sequential.
//
// Optional feature macro: PC_TRAP_EN
//   defined   : a misaligned BR loads TRAP_VEC, captures the faulting PC in
//               EPC and enters TRAP until trap_ack_i.
//   undefined : there is no TRAP state. A misaligned BR is force-aligned by
//               clearing the low INSTR_SHIFT bits of the target.
//               trap_o and epc_o read 0.
//
// Ports
//   clk_i   : clock; all state changes on the rising edge
//   reset_i : synchronous, active-high reset -> RUN at RESET_PC
//   bus     : pc_sequencer_if.slave (controls in, PC/status out)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                ADDR_W      = 64,
  parameter int                INSTR_SHIFT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(64'h80)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  pc_sequencer_if.slave         bus
);

`ifdef PC_TRAP_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01
  } state_e;
`endif

  // The sequential increment is one instruction.
  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(1) << INSTR_SHIFT;
  // The low address bits that must be zero for an aligned instruction.
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = INSTR_BYTES - ADDR_W'(1);

  // Byte offset of a word-granular branch displacement; upper bits drop
  // off, which gives the modulo-2^ADDR_W behaviour.
  function automatic logic [ADDR_W-1:0] word_to_byte(input logic [ADDR_W-1:0] imm);
    return imm << INSTR_SHIFT;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic              cond_taken;
  logic              misaligned;
  logic              taken;

  // Candidate targets and the branch condition.
  always_comb begin
    seq_pc     = pc_q + INSTR_BYTES;
    rel_pc     = pc_q + word_to_byte(bus.sign_ext_imm_i);
    cond_taken = bus.branch_i & (bus.alu_zero_i ^ bus.branch_nz_i);
    misaligned = (bus.reg_target_i & ALIGN_MASK) != '0;
  end

  // Next-state, next-PC and redirect decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    taken   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.stall_i) begin
          pc_d = pc_q;
        end else if (bus.halt_i) begin
          // Halt wins over any branch decoded in the same cycle.
          pc_d    = pc_q;
          state_d = ST_HALT;
        end else if (bus.reg_branch_i) begin
          taken = 1'b1;
          if (misaligned) begin
`ifdef PC_TRAP_EN
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            state_d = ST_TRAP;
`else
            pc_d = bus.reg_target_i & ~ALIGN_MASK;
`endif
          end else begin
            pc_d = bus.reg_target_i;
          end
        end else if (bus.uncondbranch_i) begin
          taken = 1'b1;
          pc_d  = rel_pc;
        end else if (cond_taken) begin
          taken = 1'b1;
          pc_d  = rel_pc;
        end else begin
          pc_d = seq_pc;
        end
      end
      ST_HALT: begin
        // Branch inputs are ignored; only an unstalled resume moves on.
        if (bus.resume_i && !bus.stall_i) begin
          pc_d    = seq_pc;
          state_d = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
`ifdef PC_TRAP_EN
      ST_TRAP: begin
        // The PC already holds TRAP_VEC. The acknowledge lets fetch start
        // there, and stall has no effect in this state.
        pc_d = pc_q;
        if (bus.trap_ack_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_TRAP;
        end
      end
`endif
      default: begin
        pc_d    = pc_q;
        state_d = ST_RUN;
      end
    endcase
  end

  // PC, state and EPC registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.current_pc_o = pc_q;
  assign bus.next_pc_o    = pc_d;
  assign bus.link_pc_o    = seq_pc;
  assign bus.taken_o      = taken;
  assign bus.halted_o     = (state_q == ST_HALT);
`ifdef PC_TRAP_EN
  assign bus.trap_o       = (state_q == ST_TRAP);
  assign bus.epc_o        = epc_q;
`else
  assign bus.trap_o       = 1'b0;
  assign bus.epc_o        = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (64-bit, INSTR_SHIFT = 2).
module tb_pc_sequencer;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW)) bus ();

  pc_sequencer #(
    .ADDR_W(AW), .INSTR_SHIFT(2), .RESET_PC(64'h0), .TRAP_VEC(64'h80)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus.slave)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        halted;
    logic        trap;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] pre_pc;
    logic        stall, branch, bnz, zero, uncond, regb;
    logic [63:0] target, imm;
    logic [63:0] exp_next;
    logic        exp_taken;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    bus.stall_i = 1'b0; bus.branch_i = 1'b0; bus.branch_nz_i = 1'b0;
    bus.alu_zero_i = 1'b0; bus.uncondbranch_i = 1'b0; bus.reg_branch_i = 1'b0;
    bus.reg_target_i = 64'h0; bus.sign_ext_imm_i = 64'h0; bus.halt_i = 1'b0;
    bus.resume_i = 1'b0; bus.trap_ack_i = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [63:0] pc,
                              input logic halted, input logic trap);
    exp_t e;
    e.name = name; e.pc = pc; e.halted = halted; e.trap = trap;
    exp_q.push_back(e);
  endtask

  // Clock once. Then pop the scoreboard entry pushed for this edge and check it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard: no expected entry, got pc 0x%0h", bus.current_pc_o);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".pc"},     bus.current_pc_o,     e.pc);
      check({e.name, ".halted"}, 64'(bus.halted_o),    64'(e.halted));
      check({e.name, ".trap"},   64'(bus.trap_o),      64'(e.trap));
    end
  endtask

  // Steer the PC to an aligned address through a BR.
  task automatic load_pc(input logic [63:0] addr);
    clear_inputs();
    bus.reg_branch_i = 1'b1;
    bus.reg_target_i = addr;
    expect_state("load", addr, 1'b0, 1'b0);
    step();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    expect_state("reset", 64'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    check("reset.epc", bus.epc_o, 64'h0);
  endtask

  initial begin
    //                name        pre_pc                 stl br  bnz z   unc rb  target      imm                     next                   taken
    vecs[0] = '{"cbz_taken",   64'h100,               0, 1, 0, 1, 0, 0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 64'hF0,                1};
    vecs[1] = '{"cbnz_nt",     64'h100,               0, 1, 1, 1, 0, 0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 64'h104,               0};
    vecs[2] = '{"cbz_nt",      64'h100,               0, 1, 0, 0, 0, 0, 64'h0,    64'h8,                   64'h104,               0};
    vecs[3] = '{"cbnz_taken",  64'h100,               0, 1, 1, 0, 0, 0, 64'h0,    64'h8,                   64'h120,               1};
    vecs[4] = '{"b_fwd",       64'h200,               0, 0, 0, 0, 1, 0, 64'h0,    64'h10,                  64'h240,               1};
    vecs[5] = '{"br_over_b",   64'h500,               0, 0, 0, 0, 1, 1, 64'h1000, 64'h4,                   64'h1000,              1};
    vecs[6] = '{"stall_b",     64'h600,               1, 0, 0, 0, 1, 0, 64'h0,    64'h4,                   64'h600,               0};
    vecs[7] = '{"wrap_seq",    64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0,                   64'h0,                 0};
    vecs[8] = '{"b_back_wrap", 64'h8,                 0, 0, 0, 0, 1, 0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 1};
    vecs[9] = '{"zero_no_br",  64'h700,               0, 0, 0, 1, 0, 0, 64'h0,    64'h40,                  64'h704,               0};

    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);

    // Reset, then sequential fetch.
    do_reset();
    expect_state("idle1", 64'h4, 1'b0, 1'b0); step();
    expect_state("idle2", 64'h8, 1'b0, 1'b0); step();
    expect_state("idle3", 64'hC, 1'b0, 1'b0); step();

    // Table-driven single-cycle selection checks.
    for (int i = 0; i < 10; i++) begin
      load_pc(vecs[i].pre_pc);
      bus.stall_i        = vecs[i].stall;
      bus.branch_i       = vecs[i].branch;
      bus.branch_nz_i    = vecs[i].bnz;
      bus.alu_zero_i     = vecs[i].zero;
      bus.uncondbranch_i = vecs[i].uncond;
      bus.reg_branch_i   = vecs[i].regb;
      bus.reg_target_i   = vecs[i].target;
      bus.sign_ext_imm_i = vecs[i].imm;
      #1;
      check({vecs[i].name, ".taken"},  64'(bus.taken_o), 64'(vecs[i].exp_taken));
      check({vecs[i].name, ".nextpc"}, bus.next_pc_o,    vecs[i].exp_next);
      check({vecs[i].name, ".link"},   bus.link_pc_o,    vecs[i].pre_pc + 64'h4);
      expect_state(vecs[i].name, vecs[i].exp_next, 1'b0, 1'b0);
      step();
      clear_inputs();
    end

    // Stalled B holds the PC for two cycles; LinkPC is steady throughout.
    load_pc(64'h200);
    bus.uncondbranch_i = 1'b1; bus.sign_ext_imm_i = 64'h10; bus.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("stall.link", bus.link_pc_o, 64'h204);
      expect_state("stall.hold", 64'h200, 1'b0, 1'b0);
      step();
    end
    bus.stall_i = 1'b0;
    #1 check("stall.link_rel", bus.link_pc_o, 64'h204);
    expect_state("stall.release", 64'h240, 1'b0, 1'b0);
    step();
    clear_inputs();

    // TrapAck and Resume in RUN are ignored.
    bus.trap_ack_i = 1'b1; bus.resume_i = 1'b1;
    expect_state("run.ignore", 64'h244, 1'b0, 1'b0);
    step();
    clear_inputs();

    // Misaligned BR.
    load_pc(64'h300);
    bus.reg_branch_i = 1'b1; bus.reg_target_i = 64'h2002;
`ifdef PC_TRAP_EN
    expect_state("trap.enter", 64'h80, 1'b0, 1'b1); step();
    clear_inputs();
    check("trap.epc", bus.epc_o, 64'h300);
    bus.stall_i = 1'b1;  // stall has no effect in TRAP
    for (int i = 0; i < 3; i++) begin
      expect_state("trap.hold", 64'h80, 1'b0, 1'b1); step();
    end
    bus.trap_ack_i = 1'b1;
    expect_state("trap.ack", 64'h80, 1'b0, 1'b0); step();
    clear_inputs();
    expect_state("trap.fetch", 64'h84, 1'b0, 1'b0); step();
    // Reset while trapped.
    bus.reg_branch_i = 1'b1; bus.reg_target_i = 64'h13;
    expect_state("trap.again", 64'h80, 1'b0, 1'b1); step();
    do_reset();
`else
    expect_state("misalign.align", 64'h2000, 1'b0, 1'b0); step();
    clear_inputs();
    check("misalign.epc", bus.epc_o, 64'h0);
`endif

    // Halt, hold while branch inputs wiggle, stalled resume, then resume.
    load_pc(64'h40);
    bus.halt_i = 1'b1;
    expect_state("halt.enter", 64'h40, 1'b1, 1'b0); step();
    clear_inputs();
    bus.uncondbranch_i = 1'b1; bus.sign_ext_imm_i = 64'h20;
    for (int i = 0; i < 5; i++) begin
      expect_state("halt.hold", 64'h40, 1'b1, 1'b0); step();
    end
    clear_inputs();
    bus.resume_i = 1'b1; bus.stall_i = 1'b1;
    expect_state("halt.stall_resume", 64'h40, 1'b1, 1'b0); step();
    bus.stall_i = 1'b0;
    expect_state("halt.resume", 64'h44, 1'b0, 1'b0); step();
    clear_inputs();

    // Halt together with a branch: halt wins and the branch is dropped.
    bus.halt_i = 1'b1; bus.uncondbranch_i = 1'b1; bus.sign_ext_imm_i = 64'h100;
    #1 check("halt_br.taken", 64'(bus.taken_o), 64'h0);
    expect_state("halt_br", 64'h44, 1'b1, 1'b0); step();
    clear_inputs();

    // Reset during HALT.
    do_reset();
    check("reset.halted", 64'(bus.halted_o), 64'h0);
    expect_state("post_reset", 64'h4, 1'b0, 1'b0); step();

    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard.drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
